// File: rtl/jk_bank_driver.sv
// Purpose : drives a WIDTH-bit master-slave JK flip-flop bank to a requested word,
//           then verifies Q against the target and re-drives on mismatch.
// Latency : accept edge to done_valid is 2 clocks, plus 2 per retry.
// Backpressure: req_ready is high only in IDLE; the result is held until done_ready.
//
// Ports:
//   clk, reset             clock; asynchronous active-high reset
//   req_valid/req_ready    request handshake, req_target captured on accept
//   jk_j, jk_k             registered J/K excitation to the bank (nonzero only in DRIVE)
//   q_fb                   bank Q fed back from the slave stage
//   done_valid/done_ready  result handshake
//   done_ok, done_retries  final compare result and number of retries used
module jk_bank_driver #(
  parameter int WIDTH       = 8,
  parameter int MAX_RETRY   = 3,
  parameter int TOGGLE_PREF = 0,
  localparam int RW         = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_target,
  output logic [WIDTH-1:0] jk_j,
  output logic [WIDTH-1:0] jk_k,
  input  logic [WIDTH-1:0] q_fb,
  output logic             done_valid,
  input  logic             done_ready,
  output logic             done_ok,
  output logic [RW-1:0]    done_retries
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SETTLE = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] target_r;
  logic [RW-1:0]    retry_cnt;

  // Per-bit excitation, returned as {J, K}. Bits already at target get J=K=0.
  function automatic logic [2*WIDTH-1:0] excite(input logic [WIDTH-1:0] q,
                                                input logic [WIDTH-1:0] t);
    logic [WIDTH-1:0] j;
    logic [WIDTH-1:0] k;
    if (TOGGLE_PREF != 0) begin
      j = q ^ t;
      k = q ^ t;
    end else begin
      j = ~q & t;
      k = q & ~t;
    end
    return {j, k};
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      target_r     <= '0;
      retry_cnt    <= '0;
      jk_j         <= '0;
      jk_k         <= '0;
      req_ready    <= 1'b1;
      done_valid   <= 1'b0;
      done_ok      <= 1'b0;
      done_retries <= '0;
    end else begin
      case (state)
        IDLE: begin
          // req_ready is registered high throughout IDLE, so req_valid alone accepts.
          if (req_valid) begin
            target_r       <= req_target;
            {jk_j, jk_k}   <= excite(q_fb, req_target);
            retry_cnt      <= '0;
            req_ready      <= 1'b0;
            state          <= DRIVE;
          end
        end
        DRIVE: begin
          // The bank master samples J/K on this edge; drop them to hold afterwards.
          jk_j  <= '0;
          jk_k  <= '0;
          state <= SETTLE;
        end
        SETTLE: begin
          // Slave stage updated on the preceding negedge, so q_fb is now final.
          if (q_fb == target_r) begin
            done_valid   <= 1'b1;
            done_ok      <= 1'b1;
            done_retries <= retry_cnt;
            state        <= RESP;
          end else if (retry_cnt < RW'(MAX_RETRY)) begin
            retry_cnt    <= retry_cnt + 1'b1;
            {jk_j, jk_k} <= excite(q_fb, target_r);
            state        <= DRIVE;
          end else begin
            done_valid   <= 1'b1;
            done_ok      <= 1'b0;
            done_retries <= retry_cnt;
            state        <= RESP;
          end
        end
        RESP: begin
          if (done_ready) begin
            done_valid <= 1'b0;
            req_ready  <= 1'b1;
            state      <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_jk_bank_driver.sv
// Purpose : randomized scoreboard bench for jk_bank_driver, both excitation styles.
// Two instances (set/reset and toggle) share stimulus, each driving its own JK bank.
// Expected responses are queued at issue time and compared by a negedge monitor.
module tb_jk_bank_driver;

  localparam int W  = 8;
  localparam int MR = 3;
  localparam int RW = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset      = 1'b1;
  logic         req_valid  = 1'b0;
  logic [W-1:0] req_target = '0;
  logic         done_ready = 1'b0;
  logic [W-1:0] fm         = '0;   // feedback bits forced to 0
  logic         hold       = 1'b0; // forces done_ready low

  logic          req_ready    [2];
  logic          done_valid   [2];
  logic          done_ok      [2];
  logic [RW-1:0] done_retries [2];
  logic [W-1:0]  jk_j [2];
  logic [W-1:0]  jk_k [2];
  logic [W-1:0]  q_fb [2];
  logic [W-1:0]  bm   [2];  // bank master stage
  logic [W-1:0]  bq   [2];  // bank slave stage (Q)

  assign q_fb[0] = bq[0] & ~fm;
  assign q_fb[1] = bq[1] & ~fm;

  jk_bank_driver #(.WIDTH(W), .MAX_RETRY(MR), .TOGGLE_PREF(0)) u_dut0 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready[0]),
    .req_target(req_target), .jk_j(jk_j[0]), .jk_k(jk_k[0]), .q_fb(q_fb[0]),
    .done_valid(done_valid[0]), .done_ready(done_ready), .done_ok(done_ok[0]),
    .done_retries(done_retries[0])
  );

  jk_bank_driver #(.WIDTH(W), .MAX_RETRY(MR), .TOGGLE_PREF(1)) u_dut1 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready[1]),
    .req_target(req_target), .jk_j(jk_j[1]), .jk_k(jk_k[1]), .q_fb(q_fb[1]),
    .done_valid(done_valid[1]), .done_ready(done_ready), .done_ok(done_ok[1]),
    .done_retries(done_retries[1])
  );

  // Master-slave JK bank: master samples on posedge from slave Q, slave follows on negedge.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      bm[0] <= '0;
      bm[1] <= '0;
    end else begin
      for (int i = 0; i < 2; i++)
        bm[i] <= (jk_j[i] & ~bq[i]) | (~jk_k[i] & bq[i]);
    end
  end

  always @(negedge clk or posedge reset) begin
    if (reset) begin
      bq[0] <= '0;
      bq[1] <= '0;
    end else begin
      bq[0] <= bm[0];
      bq[1] <= bm[1];
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  typedef struct packed {
    logic            ok;
    logic [1:0]      ret;
    logic [7:0]      lat;
    logic [7:0]      nz;
    logic [1:0][7:0] j0;
    logic [1:0][7:0] k0;
    logic [7:0]      qfb;
  } exp_t;

  exp_t sbq[$];
  exp_t cur;

  // Monitor state, one slot per instance.
  bit         busy [2];
  bit         pdv  [2];
  bit         phs  [2];
  int         acc  [2];
  int         nzc  [2];
  logic [7:0] j0s  [2];
  logic [7:0] k0s  [2];
  logic       hok  [2];
  logic [1:0] hret [2];

  initial begin
    cur = '0;
    for (int i = 0; i < 2; i++) begin
      busy[i] = 0; pdv[i] = 0; phs[i] = 0; acc[i] = 0; nzc[i] = 0;
      j0s[i] = '0; k0s[i] = '0; hok[i] = 1'b0; hret[i] = '0;
    end
  end

  always @(negedge clk) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        busy[i] = 0; pdv[i] = 0; phs[i] = 0;
      end
      sbq.delete();
    end else begin
      if (!pdv[0] && done_valid[0]) begin
        chk("resp_expected", 32'(sbq.size() != 0), 1);
        if (sbq.size() != 0) cur = sbq.pop_front();
      end
      for (int i = 0; i < 2; i++) begin
        if (busy[i]) begin
          if (cyc == acc[i]) begin
            j0s[i] = jk_j[i];
            k0s[i] = jk_k[i];
          end
          if ((jk_j[i] | jk_k[i]) != '0) nzc[i]++;
        end
        if (!pdv[i] && done_valid[i]) begin
          chk($sformatf("ok[%0d]", i),       done_ok[i],      cur.ok);
          chk($sformatf("retries[%0d]", i),  done_retries[i], cur.ret);
          chk($sformatf("latency[%0d]", i),  cyc - acc[i],    cur.lat);
          chk($sformatf("first_j[%0d]", i),  j0s[i],          cur.j0[i]);
          chk($sformatf("first_k[%0d]", i),  k0s[i],          cur.k0[i]);
          chk($sformatf("jk_pulses[%0d]", i), nzc[i],         cur.nz);
          chk($sformatf("q_fb[%0d]", i),     q_fb[i],         cur.qfb);
          busy[i] = 0;
          hok[i]  = done_ok[i];
          hret[i] = done_retries[i];
        end else if (pdv[i] && done_valid[i]) begin
          chk($sformatf("hold_ok[%0d]", i),      done_ok[i],      hok[i]);
          chk($sformatf("hold_retries[%0d]", i), done_retries[i], hret[i]);
          chk($sformatf("resp_ready_low[%0d]", i), req_ready[i],  0);
          chk($sformatf("resp_jk_zero[%0d]", i), jk_j[i] | jk_k[i], 0);
        end
        if (phs[i]) begin
          chk($sformatf("after_hs_valid[%0d]", i), done_valid[i], 0);
          chk($sformatf("after_hs_ready[%0d]", i), req_ready[i],  1);
        end
        phs[i] = done_valid[i] & done_ready;
        pdv[i] = done_valid[i];
        if (req_valid && req_ready[i]) begin
          busy[i] = 1;
          acc[i]  = cyc + 1;
          nzc[i]  = 0;
        end
      end
    end
  end

  // Consumer: random acceptance of results unless held off.
  initial begin
    forever begin
      @(posedge clk);
      #1 done_ready = hold ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end

  logic [W-1:0] mq = '0;  // model of bank Q

  task automatic do_req(input logic [W-1:0] t, input logic [W-1:0] f);
    exp_t         e;
    logic [W-1:0] q0;
    int           n;
    q0       = mq & ~f;
    e.ok     = ((t & f) == '0);
    e.ret    = e.ok ? 2'd0 : 2'(MR);
    e.lat    = 8'(2 * (e.ret + 1));
    e.nz     = e.ok ? 8'(q0 != t) : 8'(MR + 1);
    e.j0[0]  = ~q0 & t;
    e.k0[0]  = q0 & ~t;
    e.j0[1]  = q0 ^ t;
    e.k0[1]  = q0 ^ t;
    e.qfb    = t & ~f;
    @(posedge clk);
    #1 req_valid = 1'b1;
    req_target = t;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!req_ready[0] && n < 100);
    chk("req_accept", req_ready[0], 1);
    sbq.push_back(e);
    @(posedge clk);
    #1 req_valid = 1'b0;
    req_target = W'($urandom);
    if (f == '0) mq = t;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(req_ready[0] && req_ready[1]) && n < 100);
    chk("idle_reached", 32'(req_ready[0] && req_ready[1]), 1);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    mq = '0;
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("rst_j[%0d]", i),       jk_j[i],         0);
      chk($sformatf("rst_k[%0d]", i),       jk_k[i],         0);
      chk($sformatf("rst_ready[%0d]", i),   req_ready[i],    1);
      chk($sformatf("rst_valid[%0d]", i),   done_valid[i],   0);
      chk($sformatf("rst_ok[%0d]", i),      done_ok[i],      0);
      chk($sformatf("rst_retries[%0d]", i), done_retries[i], 0);
      chk($sformatf("rst_bank[%0d]", i),    q_fb[i],         0);
    end

    // Directed set/reset and toggle patterns
    do_req(8'hA5, 8'h00);
    do_req(8'h3C, 8'h00);
    wait_idle();

    // Randomized targets, including some that equal the current bank value
    for (int n = 0; n < 40; n++) begin
      logic [W-1:0] t;
      t = (n % 5 == 0) ? mq : W'($urandom);
      do_req(t, 8'h00);
    end
    wait_idle();

    // Stuck feedback bit: every retry is spent, result reports failure
    do_reset();
    fm = 8'h01;
    do_req(8'h01, 8'h01);
    wait_idle();
    fm = 8'h00;
    do_reset();

    // Result held off by the consumer; stray requests must be ignored
    hold = 1'b1;
    do_req(8'h5A, 8'h00);
    begin
      int n;
      n = 0;
      while (!done_valid[0] && n < 50) begin
        @(negedge clk);
        n++;
      end
      chk("hold_resp_seen", done_valid[0], 1);
    end
    repeat (5) begin
      @(posedge clk);
      #1 req_valid = 1'($urandom);
      req_target = W'($urandom);
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
    hold = 1'b0;
    wait_idle();

    // Reset mid-operation: in DRIVE, then in SETTLE
    for (int ph = 1; ph <= 2; ph++) begin
      do_req(~mq, 8'h00);
      if (ph == 2) begin
        @(posedge clk);
        #1;
      end
      reset = 1'b1;
      #1;
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("abort_j[%0d]", i),     jk_j[i],       0);
        chk($sformatf("abort_k[%0d]", i),     jk_k[i],       0);
        chk($sformatf("abort_valid[%0d]", i), done_valid[i], 0);
        chk($sformatf("abort_ready[%0d]", i), req_ready[i],  1);
      end
      repeat (2) @(posedge clk);
      #2 reset = 1'b0;
      mq = '0;
      repeat (6) begin
        @(negedge clk);
        chk("abort_no_resp", 32'(done_valid[0] | done_valid[1]), 0);
      end
      chk("abort_ready_after", 32'(req_ready[0] & req_ready[1]), 1);
    end

    // Post-abort sanity transfer
    do_req(8'hC3, 8'h00);
    wait_idle();

    begin
      int n;
      n = 0;
      while (sbq.size() != 0 && n < 50) begin
        @(negedge clk);
        n++;
      end
      chk("scoreboard_drained", sbq.size(), 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

endmodule
